// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared constants for the router packet FIFO: default geometry and the
// position of the header fields inside a DATA_W-bit header word.
//
// Header word layout (DATA_W bits):
//   [DATA_W-1:LEN_LSB]    payload length in words
//   [ADDR_MSB:ADDR_LSB]   destination address
// -----------------------------------------------------------------------------
package router_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // The length field always runs up to the word MSB, so its MSB is relative
  // to DATA_W.
  localparam int LEN_MSB_FROM_TOP = 0;
  localparam int LEN_LSB          = 2;
  localparam int ADDR_MSB         = 1;
  localparam int ADDR_LSB         = 0;

  localparam int DEF_LEN_MSB = DEF_DATA_W - 1 - LEN_MSB_FROM_TOP;

endpackage

// File: rtl/router_pkt_fifo_if.sv
// -----------------------------------------------------------------------------
// router_pkt_fifo_if
// Handshake and data bundle of the router packet FIFO.
//   master : producer/consumer side (drives write/read requests and write data)
//   slave  : the FIFO (drives read data, flags, occupancy and pkt_done)
// Signals: write_enb, read_enb, lfd_state, data_in, data_out, empty, full,
//          almost_full, count, pkt_done.
// -----------------------------------------------------------------------------
interface router_pkt_fifo_if
  import router_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              write_enb;
  logic              read_enb;
  logic              lfd_state;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic [CNT_W-1:0]  count;
  logic              pkt_done;

  modport master (
    output write_enb, read_enb, lfd_state, data_in,
    input  data_out, empty, full, almost_full, count, pkt_done
  );

  modport slave (
    input  write_enb, read_enb, lfd_state, data_in,
    output data_out, empty, full, almost_full, count, pkt_done
  );

endinterface

// File: rtl/router_fifo_mem.sv
// -----------------------------------------------------------------------------
// router_fifo_mem
// Storage array for the packet FIFO: synchronous write port, registered read
// port, plus an asynchronous peek of the entry at rd_addr so the controller
// can decode a header in the same cycle it is popped.
// Ports:
//   clk, resetn       clock, synchronous active-low reset (read register only)
//   we, wr_addr/data  write port
//   re, rd_addr       read port enable/address
//   peek              entry currently at rd_addr (combinational)
//   rd_data           registered read data, updated when re=1
// -----------------------------------------------------------------------------
module router_fifo_mem #(
  parameter int W     = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [W-1:0]             wr_data,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [W-1:0]             peek,
  output logic [W-1:0]             rd_data
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: the array is deliberately not reset; pointers and count are, so stale
  // entries can never be read out and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // A write to the slot being read on the same edge still returns the old
  // entry here, which is what a read-while-full needs.
  always_ff @(posedge clk) begin
    if (!resetn)  rd_data <= '0;
    else if (re)  rd_data <= mem[rd_addr];
  end

  assign peek = mem[rd_addr];

endmodule

// File: rtl/router_pkt_fifo.sv
// -----------------------------------------------------------------------------
// router_pkt_fifo
// Packet-aware FIFO for a router port. Each entry stores {lfd_state, data_in};
// a popped header loads a word counter with length+1 (payload plus parity) and
// pkt_done pulses on the read that consumes the last word of the packet.
// Ports:
//   clk         sole clock
//   resetn      synchronous active-low reset (highest priority)
//   soft_reset  synchronous flush of contents and packet state
//   bus         router_pkt_fifo_if.slave (requests, data, flags, count, pkt_done)
// Build option: define ROUTER_FIFO_TRISTATE_EN to drive data_out to high-Z
// when idle; otherwise idle data_out is 0.
// -----------------------------------------------------------------------------
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_LVL = DEPTH - 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic soft_reset,
  router_pkt_fifo_if.slave bus
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CNT_W   = AW + 1;
  localparam int WCNT_W  = DATA_W - 1;
  localparam int LEN_MSB = DATA_W - 1 - LEN_MSB_FROM_TOP;

  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [WCNT_W-1:0] wcnt;
  logic              pkt_done_q;
  logic              idle_q;
  logic [DATA_W:0]   peek, rd_entry;
  logic              empty_w, full_w;
  logic              rd_ok, wr_ok;
  logic              unused_bits;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CNT_W'(DEPTH));

  // Reads and writes use pre-edge flags; a write while full is accepted only
  // when a read frees the slot on the same edge. Nothing bypasses the array.
  assign rd_ok = bus.read_enb  && !empty_w && !soft_reset;
  assign wr_ok = bus.write_enb && (!full_w || rd_ok) && !soft_reset;

  router_fifo_mem #(
    .W     (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .resetn  (resetn),
    .we      (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data ({bus.lfd_state, bus.data_in}),
    .re      (rd_ok),
    .rd_addr (rd_ptr),
    .peek    (peek),
    .rd_data (rd_entry)
  );

  // NOTE: all state here uses non-blocking assignments so every register sees
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      wcnt       <= '0;
      pkt_done_q <= 1'b0;
      idle_q     <= 1'b0;
    end else if (soft_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      wcnt       <= '0;
      pkt_done_q <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      pkt_done_q <= 1'b0;
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);

      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase

      if (rd_ok) begin
        idle_q <= 1'b0;
        if (peek[DATA_W]) begin
          // Header: (re)load even mid-packet; a truncated packet never pulses.
          wcnt <= WCNT_W'(peek[LEN_MSB:LEN_LSB]) + WCNT_W'(1);
        end else if (wcnt != '0) begin
          wcnt <= wcnt - WCNT_W'(1);
          if (wcnt == WCNT_W'(1)) pkt_done_q <= 1'b1;
        end
      end else if (wcnt == '0) begin
        idle_q <= 1'b1;
      end
    end
  end

  assign bus.empty       = empty_w;
  assign bus.full        = full_w;
  assign bus.almost_full = (count_q >= CNT_W'(AFULL_LVL));
  assign bus.count       = count_q;
  assign bus.pkt_done    = pkt_done_q;

`ifdef ROUTER_FIFO_TRISTATE_EN
  assign bus.data_out = idle_q ? {DATA_W{1'bz}} : rd_entry[DATA_W-1:0];
`else
  assign bus.data_out = idle_q ? '0 : rd_entry[DATA_W-1:0];
`endif

  // Address bits and the registered lfd copy are not needed by the controller.
  assign unused_bits = ^{peek[ADDR_MSB:ADDR_LSB], rd_entry[DATA_W]};

endmodule

// File: tb/tb_router_pkt_fifo.sv
// -----------------------------------------------------------------------------
// tb_router_pkt_fifo
// Directed self-checking bench for router_pkt_fifo (DATA_W=8, DEPTH=16).
// Inputs change #1 after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_router_pkt_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

`ifdef ROUTER_FIFO_TRISTATE_EN
  localparam logic [DATA_W-1:0] IDLE = 8'bzzzz_zzzz;
`else
  localparam logic [DATA_W-1:0] IDLE = 8'h00;
`endif

  logic clk = 1'b0;
  logic resetn;
  logic soft_reset;

  int checks   = 0;
  int failures = 0;

  router_pkt_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  router_pkt_fifo #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AFULL_LVL (DEPTH - 2)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic lfd, input logic [DATA_W-1:0] d);
    bus.write_enb = 1'b1;
    bus.lfd_state = lfd;
    bus.data_in   = d;
    tick();
    bus.write_enb = 1'b0;
    bus.lfd_state = 1'b0;
    bus.data_in   = '0;
  endtask

  task automatic pop();
    bus.read_enb = 1'b1;
    tick();
    bus.read_enb = 1'b0;
  endtask

  // Packet 1: header len=5 addr=1, six words (5 payload + parity).
  logic [DATA_W-1:0] pkt1 [7] = '{8'h15, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};

  initial begin
    resetn         = 1'b0;
    soft_reset     = 1'b0;
    bus.write_enb  = 1'b0;
    bus.read_enb   = 1'b0;
    bus.lfd_state  = 1'b0;
    bus.data_in    = '0;

    // ---------------- reset state
    tick();
    tick();
    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_afull", bus.almost_full, 0);
    check("rst_pkt_done", bus.pkt_done, 0);
    check("rst_data_out", bus.data_out, 0);
    resetn = 1'b1;
    tick();

    // ---------------- full packet in, full packet out
    for (int i = 0; i < 7; i++) push(i == 0, pkt1[i]);
    check("p1_count", bus.count, 7);
    for (int i = 0; i < 7; i++) begin
      pop();
      check($sformatf("p1_data%0d", i), bus.data_out, pkt1[i]);
      check($sformatf("p1_done%0d", i), bus.pkt_done, (i == 6) ? 1 : 0);
    end
    check("p1_empty", bus.empty, 1);
    tick();
    check("p1_done_pulse", bus.pkt_done, 0);
    check("p1_idle", bus.data_out, IDLE);

    // ---------------- fill past full
    for (int k = 0; k < 17; k++) begin
      push(1'b0, 8'(8'h10 + k));
      check($sformatf("fill_count%0d", k), bus.count, (k < 16) ? k + 1 : 16);
      check($sformatf("fill_full%0d", k), bus.full, (k >= 15) ? 1 : 0);
      check($sformatf("fill_afull%0d", k), bus.almost_full, (k >= 13) ? 1 : 0);
    end

    // ---------------- simultaneous read/write while full
    bus.write_enb = 1'b1;
    bus.read_enb  = 1'b1;
    bus.data_in   = 8'hEE;
    tick();
    bus.write_enb = 1'b0;
    bus.read_enb  = 1'b0;
    bus.data_in   = '0;
    check("rw_full_count", bus.count, 16);
    check("rw_full_data", bus.data_out, 8'h10);
    check("rw_full_full", bus.full, 1);
    for (int i = 0; i < 16; i++) begin
      pop();
      check($sformatf("drain_data%0d", i), bus.data_out, (i < 15) ? 8'(8'h11 + i) : 8'hEE);
    end
    check("drain_empty", bus.empty, 1);
    check("drain_pkt_done", bus.pkt_done, 0);

    // ---------------- soft reset mid-packet
    push(1'b1, 8'h14);
    for (int i = 0; i < 6; i++) push(1'b0, 8'(8'h31 + i));
    pop();
    pop();
    pop();
    check("sr_pre_data", bus.data_out, 8'h32);
    soft_reset    = 1'b1;
    bus.read_enb  = 1'b1;
    bus.write_enb = 1'b1;
    bus.data_in   = 8'h99;
    tick();
    soft_reset    = 1'b0;
    bus.read_enb  = 1'b0;
    bus.write_enb = 1'b0;
    bus.data_in   = '0;
    check("sr_count", bus.count, 0);
    check("sr_empty", bus.empty, 1);
    check("sr_data_out", bus.data_out, IDLE);
    check("sr_pkt_done", bus.pkt_done, 0);
    tick();
    check("sr_pkt_done_after", bus.pkt_done, 0);

    // ---------------- read on empty holds data mid-packet; header reload
    push(1'b1, 8'h08);               // len=2 -> counter 3
    pop();
    check("re_hdr", bus.data_out, 8'h08);
    pop();                           // FIFO empty now
    check("re_empty_data", bus.data_out, 8'h08);
    check("re_empty_count", bus.count, 0);
    push(1'b0, 8'h41);
    push(1'b1, 8'h06);               // len=1 addr=2 -> counter 2
    push(1'b0, 8'h51);
    push(1'b0, 8'h52);
    pop();
    check("rl_d41", bus.data_out, 8'h41);
    check("rl_done41", bus.pkt_done, 0);
    pop();
    check("rl_hdr", bus.data_out, 8'h06);
    check("rl_done_hdr", bus.pkt_done, 0);
    pop();
    check("rl_d51", bus.data_out, 8'h51);
    check("rl_done51", bus.pkt_done, 0);
    pop();
    check("rl_d52", bus.data_out, 8'h52);
    check("rl_done52", bus.pkt_done, 1);
    tick();
    check("rl_done_clear", bus.pkt_done, 0);
    check("rl_idle", bus.data_out, IDLE);

    // ---------------- hard reset during simultaneous read/write
    push(1'b0, 8'h77);
    push(1'b0, 8'h78);
    pop();
    check("hr_pre_data", bus.data_out, 8'h77);
    resetn        = 1'b0;
    bus.write_enb = 1'b1;
    bus.read_enb  = 1'b1;
    bus.data_in   = 8'h5A;
    tick();
    bus.write_enb = 1'b0;
    bus.read_enb  = 1'b0;
    bus.data_in   = '0;
    check("hr_count", bus.count, 0);
    check("hr_empty", bus.empty, 1);
    check("hr_full", bus.full, 0);
    check("hr_afull", bus.almost_full, 0);
    check("hr_pkt_done", bus.pkt_done, 0);
    check("hr_data_out", bus.data_out, 0);
    resetn = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
